// File: rtl/sweep_ctrl.sv
// Frequency-sweep scheduler: steps the divided counter's skip ratio between
// latched bounds, holding each value for dwell+1 cycles.
module sweep_ctrl #(
    parameter int WIDTH   = 8,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [WIDTH-1:0]   f_lo,
    input  logic [WIDTH-1:0]   f_hi,
    input  logic [WIDTH-1:0]   f_step,
    input  logic [DWELL_W-1:0] dwell,
    output logic [WIDTH-1:0]   skip,
    output logic               gen_en,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   skip_q, skip_d;
    logic [WIDTH-1:0]   lo_q, lo_d, hi_q, hi_d, step_q, step_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d, cnt_q, cnt_d;
    logic               mode_q, mode_d;
    logic               done_q, done_d, err_q, err_d;

    logic [WIDTH:0]     sum_w, diff_w;
    logic [WIDTH-1:0]   up_nxt, dn_nxt;
    logic               cfg_bad, expire;

    // Extra carry/borrow bit so the clamps see overflow instead of a wrapped value.
    assign sum_w   = {1'b0, skip_q} + {1'b0, step_q};
    assign diff_w  = {1'b0, skip_q} - {1'b0, step_q};
    assign up_nxt  = (sum_w > {1'b0, hi_q}) ? hi_q : sum_w[WIDTH-1:0];
    assign dn_nxt  = (diff_w[WIDTH] || (diff_w[WIDTH-1:0] < lo_q)) ? lo_q : diff_w[WIDTH-1:0];
    assign cfg_bad = (f_lo == '0) || (f_step == '0) || (f_lo > f_hi);
    assign expire  = (cnt_q == dwell_q);

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        step_d  = step_q;
        dwell_d = dwell_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    lo_d    = f_lo;
                    hi_d    = f_hi;
                    step_d  = f_step;
                    dwell_d = dwell;
                    mode_d  = mode;
                    if (cfg_bad) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = UP;
                        skip_d  = f_lo;
                        cnt_d   = '0;
                    end
                end
            end
            UP, DOWN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (!expire) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = '0;
                    if (state_q == UP) begin
                        if (skip_q == hi_q) begin
                            if (mode_q) begin
                                state_d = DOWN;
                                skip_d  = dn_nxt;
                            end else begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            skip_d = up_nxt;
                        end
                    end else begin
                        // At lo, skip+step equals lo+step, so the up path serves the turnaround.
                        if (skip_q == lo_q) begin
                            state_d = UP;
                            skip_d  = up_nxt;
                        end else begin
                            skip_d = dn_nxt;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            skip_q  <= WIDTH'(1);
            lo_q    <= '0;
            hi_q    <= '0;
            step_q  <= '0;
            dwell_q <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            step_q  <= step_d;
            dwell_q <= dwell_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign skip   = skip_q;
    assign busy   = (state_q != IDLE);
    assign gen_en = (state_q != IDLE);
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Directed bench for sweep_ctrl: hand-computed skip sequences, clamps,
// invalid starts, stop/start collisions and async reset.
module tb_sweep_ctrl;
    logic        clk = 1'b0;
    logic        rst, start, stop, mode;
    logic [7:0]  f_lo, f_hi, f_step;
    logic [15:0] dwell;
    logic [7:0]  skip;
    logic        gen_en, busy, done, err;

    int checks = 0;
    int failures = 0;
    int exp_q[$];

    sweep_ctrl #(.WIDTH(8), .DWELL_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
        .f_lo(f_lo), .f_hi(f_hi), .f_step(f_step), .dwell(dwell),
        .skip(skip), .gen_en(gen_en), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        if (obs != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int lo, input int hi, input int stp, input int dw, input bit md);
        f_lo = 8'(lo); f_hi = 8'(hi); f_step = 8'(stp); dwell = 16'(dw); mode = md;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Each queued value must be visible for 'hold' cycles with busy high and no pulses.
    task automatic run_seq(input string tag, input int hold);
        int v;
        while (exp_q.size() > 0) begin
            v = exp_q.pop_front();
            for (int h = 0; h < hold; h++) begin
                chk({tag, "_skip"}, int'(skip), v);
                chk({tag, "_busy"}, int'(busy), 1);
                chk({tag, "_gen_en"}, int'(gen_en), 1);
                chk({tag, "_done"}, int'(done), 0);
                step();
            end
        end
    endtask

    task automatic chk_finish(input string tag, input int hi);
        chk({tag, "_done_pulse"}, int'(done), 1);
        chk({tag, "_busy_low"}, int'(busy), 0);
        chk({tag, "_gen_en_low"}, int'(gen_en), 0);
        chk({tag, "_skip_hold"}, int'(skip), hi);
        step();
        chk({tag, "_done_clear"}, int'(done), 0);
        chk({tag, "_skip_hold2"}, int'(skip), hi);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0;
        f_lo = '0; f_hi = '0; f_step = '0; dwell = '0;
        step(); step();
        chk("rst_skip", int'(skip), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_gen_en", int'(gen_en), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        rst = 1'b0;
        step();

        // One-shot basic: 2,4,6 x4 cycles
        do_start(2, 6, 2, 3, 1'b0);
        exp_q = '{2, 4, 6};
        run_seq("basic", 4);
        chk_finish("basic", 6);

        // Overflow clamp at hi
        do_start(1, 6, 4, 0, 1'b0);
        exp_q = '{1, 5, 6};
        run_seq("ovf", 1);
        chk_finish("ovf", 6);

        // No wrap past the 8-bit range
        do_start(200, 255, 100, 0, 1'b0);
        exp_q = '{200, 255};
        run_seq("wrap", 1);
        chk_finish("wrap", 255);

        // lo==hi one-shot: a single dwell period
        do_start(3, 3, 1, 2, 1'b0);
        exp_q = '{3};
        run_seq("eq1", 3);
        chk_finish("eq1", 3);

        // Bounce with underflow clamp; start and config changes held mid-sweep are ignored
        do_start(1, 5, 3, 1, 1'b1);
        start = 1'b1; f_lo = 8'd7; f_hi = 8'd9; f_step = 8'd1; dwell = 16'd0; mode = 1'b0;
        exp_q = '{1, 4, 5, 2, 1, 4};
        run_seq("bounce", 2);
        start = 1'b0;
        chk("bounce_next", int'(skip), 5);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_busy", int'(busy), 0);
        chk("stop_gen_en", int'(gen_en), 0);
        chk("stop_done", int'(done), 0);
        chk("stop_skip", int'(skip), 5);
        step();
        chk("stop_skip2", int'(skip), 5);

        // lo==hi bounce: skip constant, never done
        do_start(4, 4, 2, 0, 1'b1);
        exp_q = '{4, 4, 4, 4, 4};
        run_seq("eqb", 1);
        stop = 1'b1; step(); stop = 1'b0;
        chk("eqb_stop_busy", int'(busy), 0);

        // Stop on a dwell-expiry cycle: no skip update, no done
        do_start(2, 6, 2, 3, 1'b0);
        exp_q = '{2};
        run_seq("stopexp", 3);
        stop = 1'b1; step(); stop = 1'b0;
        chk("stopexp_busy", int'(busy), 0);
        chk("stopexp_skip", int'(skip), 2);
        chk("stopexp_done", int'(done), 0);

        // Invalid configs: err pulse, stay idle, skip unchanged
        do_start(5, 3, 1, 0, 1'b0);
        chk("inv_hilo_err", int'(err), 1);
        chk("inv_hilo_busy", int'(busy), 0);
        chk("inv_hilo_skip", int'(skip), 2);
        step();
        chk("inv_hilo_err_clr", int'(err), 0);
        do_start(0, 3, 1, 0, 1'b0);
        chk("inv_lo0_err", int'(err), 1);
        chk("inv_lo0_busy", int'(busy), 0);
        chk("inv_lo0_skip", int'(skip), 2);
        step();
        do_start(1, 3, 0, 0, 1'b0);
        chk("inv_step0_err", int'(err), 1);
        chk("inv_step0_busy", int'(busy), 0);
        chk("inv_step0_skip", int'(skip), 2);
        step();
        chk("inv_step0_err_clr", int'(err), 0);

        // start+stop together in IDLE: nothing happens
        f_lo = 8'd1; f_hi = 8'd3; f_step = 8'd1; dwell = '0;
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        chk("ss_busy", int'(busy), 0);
        chk("ss_err", int'(err), 0);
        chk("ss_skip", int'(skip), 2);

        // Async reset between edges during UP
        do_start(2, 6, 2, 3, 1'b0);
        step(); step();
        #2 rst = 1'b1;
        #1;
        chk("arst_skip", int'(skip), 1);
        chk("arst_busy", int'(busy), 0);
        chk("arst_gen_en", int'(gen_en), 0);
        rst = 1'b0;
        step();
        do_start(2, 6, 2, 3, 1'b0);
        exp_q = '{2, 4, 6};
        run_seq("post_rst", 4);
        chk_finish("post_rst", 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
